// File: rtl/inst_axi_rd_bridge_if.sv
// Signal bundle between the fetch stage, the instruction bridge and the AXI read channels.
// The master view belongs to the bridge; the slave view to the fetch stage plus AXI slave.
interface inst_axi_rd_bridge_if;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic [3:0]  axi_arid;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
           inst_sram_addr, inst_sram_wdata,
           arready, rid, rdata, rresp, rlast, rvalid,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata, axi_arid,
           arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
           arvalid, rready
  );

  modport slave (
    output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
           inst_sram_addr, inst_sram_wdata,
           arready, rid, rdata, rresp, rlast, rvalid,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata, axi_arid,
           arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
           arvalid, rready
  );
endinterface

// File: rtl/inst_axi_rd_bridge.sv
// Fetch-side SRAM-like port to AXI4 single-beat read bridge; in-order responses,
// at most MAX_OUT accepted-but-unanswered requests.
module inst_axi_rd_bridge #(
  parameter logic [3:0] ARID    = 4'd0,
  parameter int         MAX_OUT = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  inst_axi_rd_bridge_if.master  bus
);
  localparam logic [1:0] MAX_CNT = 2'(MAX_OUT);

  typedef enum logic {AR_IDLE = 1'b0, AR_SEND = 1'b1} ar_state_t;

  ar_state_t   state, state_nxt;
  logic [1:0]  out_cnt;
  logic [31:0] araddr_q;
  logic        data_ok_p1;
  logic [31:0] rdata_p1;
  logic        addr_ok;
  logic        ar_hs;
  logic        r_hs;
  logic        rready_c;
  logic        unused_inputs;

  // Writes, sizes, IDs, response codes and rlast carry no information for this bridge.
  assign unused_inputs = ^{bus.inst_sram_wr, bus.inst_sram_size, bus.inst_sram_wstrb,
                           bus.inst_sram_wdata, bus.rid, bus.rresp, bus.rlast};

  // Never accept while an AR is pending, so araddr stays stable until its handshake.
  assign addr_ok  = bus.inst_sram_req && (state == AR_IDLE) && (out_cnt < MAX_CNT);
  assign ar_hs    = (state == AR_SEND) && bus.arready;
  assign rready_c = (out_cnt != 2'd0);
  assign r_hs     = bus.rvalid && rready_c;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= AR_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      AR_IDLE: if (addr_ok) state_nxt = AR_SEND;
      AR_SEND: if (ar_hs)   state_nxt = AR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      araddr_q <= 32'd0;
      out_cnt  <= 2'd0;
    end else begin
      if (addr_ok) araddr_q <= bus.inst_sram_addr;
      case ({addr_ok, r_hs})
        2'b10:   out_cnt <= out_cnt + 2'd1;
        2'b01:   out_cnt <= out_cnt - 2'd1;
        default: out_cnt <= out_cnt;
      endcase
    end
  end

  // R capture stage: data_ok pulses the cycle after each R handshake.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_ok_p1 <= 1'b0;
      rdata_p1   <= 32'd0;
    end else begin
      data_ok_p1 <= r_hs;
      if (r_hs) rdata_p1 <= bus.rdata;
    end
  end

  assign bus.inst_sram_addr_ok = addr_ok;
  assign bus.inst_sram_data_ok = data_ok_p1;
  assign bus.inst_sram_rdata   = rdata_p1;
  assign bus.axi_arid          = ARID;
  assign bus.arid              = ARID;
  assign bus.araddr            = araddr_q;
  assign bus.arlen             = 8'd0;
  assign bus.arsize            = 3'b010;
  assign bus.arburst           = 2'b01;
  assign bus.arlock            = 2'b00;
  assign bus.arcache           = 4'd0;
  assign bus.arprot            = 3'd0;
  assign bus.arvalid           = (state == AR_SEND);
  assign bus.rready            = rready_c;

  // A response with nothing outstanding means the slave broke the protocol.
  a_no_orphan_r: assert property (@(posedge clk) disable iff (!resetn)
    !(bus.rvalid && (out_cnt == 2'd0)));
endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Directed bench for inst_axi_rd_bridge: stimulus pushes expected read data,
// a negedge monitor pops and compares on every data_ok pulse.
module tb_inst_axi_rd_bridge;
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  inst_axi_rd_bridge_if bus();

  inst_axi_rd_bridge #(.ARID(4'd0), .MAX_OUT(2)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive_r(input logic [31:0] d);
    bus.rvalid = 1'b1;
    bus.rdata  = d;
    exp_q.push_back(d);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (resetn === 1'b1 && bus.inst_sram_data_ok === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL data_ok_unexpected: got rdata 0x%08h, required no pulse", bus.inst_sram_rdata);
      end else begin
        mon_exp = exp_q.pop_front();
        check("sb_rdata", bus.inst_sram_rdata, mon_exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

  // Minimum-latency fetch: addr_ok at t, AR at t+1, R at t+2, data_ok at t+3.
  task automatic single_fetch(input logic [31:0] a, input logic [31:0] d);
    step(); bus.inst_sram_req = 1'b1; bus.inst_sram_addr = a; bus.arready = 1'b1;
    sample(); check("sf_addr_ok_t", bus.inst_sram_addr_ok, 1);
    step(); bus.inst_sram_req = 1'b0;
    sample();
    check("sf_arvalid_t1", bus.arvalid, 1);
    check("sf_araddr_t1", bus.araddr, a);
    check("sf_arsize", bus.arsize, 3'b010);
    check("sf_arlen", bus.arlen, 0);
    check("sf_arid", bus.arid, 0);
    check("sf_axi_arid", bus.axi_arid, 0);
    step(); drive_r(d);
    sample();
    check("sf_rready_t2", bus.rready, 1);
    check("sf_data_ok_t2", bus.inst_sram_data_ok, 0);
    check("sf_arvalid_t2", bus.arvalid, 0);
    step(); bus.rvalid = 1'b0;
    sample();
    check("sf_data_ok_t3", bus.inst_sram_data_ok, 1);
    check("sf_rdata_t3", bus.inst_sram_rdata, d);
    check("sf_rready_t3", bus.rready, 0);
    step();
    sample(); check("sf_data_ok_pulse", bus.inst_sram_data_ok, 0);
  endtask

  initial begin
    bus.inst_sram_req   = 1'b0;
    bus.inst_sram_wr    = 1'b0;
    bus.inst_sram_size  = 2'd2;
    bus.inst_sram_wstrb = 4'd0;
    bus.inst_sram_addr  = 32'd0;
    bus.inst_sram_wdata = 32'd0;
    bus.arready         = 1'b0;
    bus.rid             = 4'd0;
    bus.rdata           = 32'd0;
    bus.rresp           = 2'd0;
    bus.rlast           = 1'b1;
    bus.rvalid          = 1'b0;
    resetn              = 1'b1;
    #2 resetn = 1'b0;
    #1;
    check("rst_arvalid", bus.arvalid, 0);
    check("rst_rready", bus.rready, 0);
    check("rst_data_ok", bus.inst_sram_data_ok, 0);
    check("rst_rdata", bus.inst_sram_rdata, 0);
    check("rst_araddr", bus.araddr, 0);
    check("rst_arsize", bus.arsize, 3'b010);
    check("rst_arburst", bus.arburst, 2'b01);
    check("rst_arlen", bus.arlen, 0);
    check("rst_consts", {bus.arlock, bus.arcache, bus.arprot}, 0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    // Single fetch
    single_fetch(32'h1C00_0000, 32'h0280_0C0C);

    // AR backpressure: five stalled cycles with req held high
    step(); bus.inst_sram_req = 1'b1; bus.inst_sram_addr = 32'h1C00_0010; bus.arready = 1'b0;
    sample(); check("bp_addr_ok", bus.inst_sram_addr_ok, 1);
    for (int i = 0; i < 5; i++) begin
      step(); bus.inst_sram_addr = 32'h1C00_0014;
      sample();
      check("bp_arvalid_stable", bus.arvalid, 1);
      check("bp_araddr_stable", bus.araddr, 32'h1C00_0010);
      check("bp_no_addr_ok", bus.inst_sram_addr_ok, 0);
    end
    step(); bus.arready = 1'b1; bus.inst_sram_req = 1'b0;
    sample(); check("bp_arvalid_6th", bus.arvalid, 1);
    step(); drive_r(32'hAAAA_0001);
    sample(); check("bp_arvalid_done", bus.arvalid, 0);
    step(); bus.rvalid = 1'b0;
    sample(); check("bp_cnt_zero", dut.out_cnt, 0);

    // Outstanding limit and in-order return
    step(); bus.inst_sram_req = 1'b1; bus.inst_sram_addr = 32'h1C00_0000;
    sample(); check("ol_addr_ok_1", bus.inst_sram_addr_ok, 1);
    step(); bus.inst_sram_addr = 32'h1C00_0004;
    sample(); check("ol_no_ok_send", bus.inst_sram_addr_ok, 0);
    step();
    sample(); check("ol_addr_ok_2", bus.inst_sram_addr_ok, 1);
    step(); bus.inst_sram_addr = 32'h1C00_0008;
    sample();
    check("ol_cnt_2", dut.out_cnt, 2);
    check("ol_araddr_2", bus.araddr, 32'h1C00_0004);
    step();
    sample();
    check("ol_limit_no_ok", bus.inst_sram_addr_ok, 0);
    check("ol_limit_cnt", dut.out_cnt, 2);
    step(); drive_r(32'h1111_1111);
    sample(); check("ol_limit_no_ok_r", bus.inst_sram_addr_ok, 0);
    step(); bus.rvalid = 1'b0;
    sample(); check("ol_reassert", bus.inst_sram_addr_ok, 1);
    step(); bus.inst_sram_req = 1'b0;
    sample();
    check("ol_cnt_again_2", dut.out_cnt, 2);
    check("ol_araddr_3", bus.araddr, 32'h1C00_0008);
    step(); drive_r(32'h2222_2222);
    sample();
    step(); bus.rdata = 32'h3333_3333; exp_q.push_back(32'h3333_3333);
    sample(); check("io_rready_mid", bus.rready, 1);
    step(); bus.rvalid = 1'b0;
    sample();
    check("io_cnt_zero", dut.out_cnt, 0);
    check("io_rready_drop", bus.rready, 0);

    // Simultaneous addr_ok and R handshake
    step(); bus.inst_sram_req = 1'b1; bus.inst_sram_addr = 32'h1C00_0020;
    sample();
    step(); bus.inst_sram_req = 1'b0;
    sample();
    step(); bus.inst_sram_req = 1'b1; bus.inst_sram_addr = 32'h1C00_0024; drive_r(32'h4444_4444);
    sample();
    check("sim_addr_ok", bus.inst_sram_addr_ok, 1);
    check("sim_cnt_before", dut.out_cnt, 1);
    step(); bus.inst_sram_req = 1'b0; bus.rvalid = 1'b0;
    sample();
    check("sim_cnt_unchanged", dut.out_cnt, 1);
    check("sim_araddr", bus.araddr, 32'h1C00_0024);
    check("sim_data_ok", bus.inst_sram_data_ok, 1);
    step(); drive_r(32'h5555_5555);
    sample();
    step(); bus.rvalid = 1'b0;
    sample(); check("sim_cnt_zero", dut.out_cnt, 0);

    // Asynchronous reset with an AR pending, one read outstanding and data_ok high
    step(); bus.inst_sram_req = 1'b1; bus.inst_sram_addr = 32'h1C00_0030;
    sample();
    step(); bus.inst_sram_req = 1'b0;
    sample();
    step(); bus.inst_sram_req = 1'b1; bus.inst_sram_addr = 32'h1C00_0034; drive_r(32'h6666_6666);
    sample();
    step(); bus.inst_sram_req = 1'b0; bus.rvalid = 1'b0; bus.arready = 1'b0;
    sample();
    check("ar_pre_arvalid", bus.arvalid, 1);
    check("ar_pre_cnt", dut.out_cnt, 1);
    #2 resetn = 1'b0;
    #1;
    check("ar_arvalid_async", bus.arvalid, 0);
    check("ar_rready_async", bus.rready, 0);
    check("ar_data_ok_async", bus.inst_sram_data_ok, 0);
    check("ar_araddr_async", bus.araddr, 0);
    step();
    step(); resetn = 1'b1;
    single_fetch(32'h1C00_0040, 32'h1234_5678);

    step();
    sample(); check("sb_queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
